// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART transmitter and receiver.
//   - 3-bit state encodings for the serial frame FSMs, plus an enum that uses them
//   - default data width (NBIT_DATA_LEN) and oversampling factor (NUM_TICKS_DEF)
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int NBIT_DATA_LEN = 8;
  localparam int NUM_TICKS_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if
// Host-side request and serial-line bundle for the UART transmitter.
//   tx_start     : request to send data_in (strobe or level)
//   data_in      : word to transmit
//   tx           : serial line, idle high
//   tx_busy      : frame in progress
//   tx_done_tick : one-clk pulse at the end of the stop period
// Modports: master = host driving requests, slave = transmitter.
interface uart_tx_if #(
  parameter int NBIT_DATA = 8
);

  logic                 tx_start;
  logic [NBIT_DATA-1:0] data_in;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done_tick;

  modport master (
    output tx_start,
    output data_in,
    input  tx,
    input  tx_busy,
    input  tx_done_tick
  );

  modport slave (
    input  tx_start,
    input  data_in,
    output tx,
    output tx_busy,
    output tx_done_tick
  );

endinterface

// File: rtl/uart_tx.sv
// uart_tx
// UART transmitter. Sends one NBIT_DATA-bit word per accepted request as
// start bit, data LSB first, optional parity bit, then stop period. Bit
// timing is NUM_TICKS baud ticks per bit; the stop period is SB_TICKS ticks.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   tick  : one-clk baud enable from the baud rate generator
//   bus   : uart_tx_if.slave (tx_start, data_in, tx, tx_busy, tx_done_tick)
// All outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int NBIT_DATA     = NBIT_DATA_LEN,
  parameter int NUM_TICKS     = NUM_TICKS_DEF,
  parameter int LEN_NUM_TICKS = 5,
  parameter int SB_TICKS      = 16,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      tick,
  uart_tx_if.slave  bus
);

  localparam int LEN_BIT = (NBIT_DATA > 1) ? $clog2(NBIT_DATA) : 1;

  localparam logic [LEN_NUM_TICKS-1:0] TICK_LAST = LEN_NUM_TICKS'(NUM_TICKS - 1);
  localparam logic [LEN_NUM_TICKS-1:0] SB_LAST   = LEN_NUM_TICKS'(SB_TICKS - 1);
  localparam logic [LEN_BIT-1:0]       BIT_LAST  = LEN_BIT'(NBIT_DATA - 1);

  state_t                   state_reg, state_next;
  logic [LEN_NUM_TICKS-1:0] tick_cnt_reg, tick_cnt_next;
  logic [LEN_BIT-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [NBIT_DATA-1:0]     shift_reg, shift_next;
  // Untouched copy of the accepted word; parity is taken from this, since
  // the shift register has been emptied by the time the parity bit goes out.
  logic [NBIT_DATA-1:0]     word_reg, word_next;
  logic                     tx_reg, tx_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;
  logic                     parity_bit;

  assign parity_bit = (^word_next) ^ (PARITY_ODD != 0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      word_reg     <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      word_reg     <= word_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    word_next     = word_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        // tick is deliberately ignored in the acceptance cycle.
        if (bus.tx_start) begin
          shift_next    = bus.data_in;
          word_next     = bus.data_in;
          tick_cnt_next = '0;
          state_next    = START;
        end
      end

      START: begin
        if (tick) begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = DATA;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            shift_next    = shift_reg >> 1;
            if (bit_cnt_reg == BIT_LAST) begin
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            state_next    = STOP;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      STOP: begin
        // The done pulse is issued while still in STOP, so a request that
        // coincides with it is ignored; IDLE follows on the next clk.
        if (done_reg) begin
          state_next = IDLE;
        end else if (tick) begin
          if (tick_cnt_reg == SB_LAST) begin
            tick_cnt_next = '0;
            done_next     = 1'b1;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next    = IDLE;
        tick_cnt_next = '0;
        bit_cnt_next  = '0;
      end
    endcase

    // Line level is decoded from the next state so tx changes on the same
    // edge as the state register.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_bit;
      default: tx_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE);
  end

  assign bus.tx           = tx_reg;
  assign bus.tx_busy      = busy_reg;
  assign bus.tx_done_tick = done_reg;

endmodule
